mxint_cast_arbiter: RTL and testbench

Round-robin scheduler that shares one MxInt cast engine among NUM_REQ block-stream requesters, e.g. the Q/K/V projection outputs of the attention layer. It grants one requester at a time for a burst of up to BURST_LEN blocks and forwards those blocks to the external cast engine. Each accepted block gets the requester's tag, and the cast results are routed back to the originating requester in order. Sits between the producing layers and a single shared cast instance, replacing per-stream cast instances.

---
 rtl/mxint_cast_arb_pkg.sv | 33 +++
 rtl/mxint_tag_fifo.sv | 47 ++++
 rtl/mxint_cast_arbiter.sv | 150 +++++++++++++++
 tb/tb_mxint_cast_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_cast_arb_pkg.sv
// Shared types and helpers for the MxInt cast arbiter: FSM state, tag sizing
// and the round-robin pick used when a new grant is issued.
package mxint_cast_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Widest requester mask rr_next can rotate over.
   localparam int RR_MAX = 32;

   function automatic int tag_width(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

   // Index of the first set bit of mask[n-1:0] at or after ptr, wrapping.
   // Scanning from the farthest offset down lets the nearest hit win without a break.
   function automatic int rr_next(input logic [RR_MAX-1:0] mask, input int ptr, input int n);
      int result;
      int idx;
      result = ptr;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (mask[idx]) result = idx;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/mxint_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each block inside the cast engine.
// Head is read combinationally so the return path adds no register stage.
module mxint_tag_fifo #(
   parameter int TAG_WIDTH = 2,
   parameter int DEPTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [TAG_WIDTH-1:0] push_tag,
   input  logic                 pop,
   output logic [TAG_WIDTH-1:0] head,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(DEPTH);

   logic [TAG_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]          wr_ptr_reg;
   logic [AW:0]          rd_ptr_reg;
   logic                 push_en;
   logic                 pop_en;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr_reg[AW-1:0]] <= push_tag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mxint_cast_arbiter.sv
// Round-robin burst arbiter sharing one MxInt cast engine among NUM_REQ block streams,
// routing results back by tag. Define MXINT_CAST_ARB_STATS_EN for per-requester block counters.
module mxint_cast_arbiter
   import mxint_cast_arb_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int IN_MAN_WIDTH  = 8,
   parameter int IN_EXP_WIDTH  = 8,
   parameter int OUT_MAN_WIDTH = 8,
   parameter int OUT_EXP_WIDTH = 8,
   parameter int BLOCK_SIZE    = 4,
   parameter int BURST_LEN     = 4,
   parameter int MAX_INFLIGHT  = 8
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  req_mdata,
   input  logic [NUM_REQ-1:0][IN_EXP_WIDTH-1:0]                  req_edata,
   input  logic [NUM_REQ-1:0]                                    req_valid,
   output logic [NUM_REQ-1:0]                                    req_ready,
   output logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]               cast_mdata_in,
   output logic [IN_EXP_WIDTH-1:0]                               cast_edata_in,
   output logic                                                  cast_in_valid,
   input  logic                                                  cast_in_ready,
   input  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]              cast_mdata_out,
   input  logic [OUT_EXP_WIDTH-1:0]                              cast_edata_out,
   input  logic                                                  cast_out_valid,
   output logic                                                  cast_out_ready,
   output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]              rsp_mdata,
   output logic [OUT_EXP_WIDTH-1:0]                              rsp_edata,
   output logic [NUM_REQ-1:0]                                    rsp_valid,
   input  logic [NUM_REQ-1:0]                                    rsp_ready
`ifdef MXINT_CAST_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][31:0]                              stat_blocks
`endif
);

   localparam int TAG_W  = tag_width(NUM_REQ);
   localparam int BEAT_W = tag_width(BURST_LEN);

   arb_state_t        state_reg, state_next;
   logic [TAG_W-1:0]  grant_reg, grant_next;
   logic [TAG_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

   logic              in_hs;
   logic              out_hs;
   logic              fifo_full;
   logic              fifo_empty;
   logic [TAG_W-1:0]  fifo_head;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      req_ready     = '0;
      cast_in_valid = 1'b0;
      in_hs         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               grant_next    = TAG_W'(rr_next(RR_MAX'(req_valid), int'(rr_ptr_reg), NUM_REQ));
               beat_cnt_next = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            cast_in_valid        = req_valid[grant_reg] & ~fifo_full;
            req_ready[grant_reg] = cast_in_ready & ~fifo_full;
            in_hs                = cast_in_valid & cast_in_ready;
            if (in_hs) beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            // A dropped valid releases the grant just like a completed burst.
            if (!req_valid[grant_reg] ||
                (in_hs && (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)))) begin
               state_next  = IDLE;
               rr_ptr_next = (grant_reg == TAG_W'(NUM_REQ - 1)) ? '0 : grant_reg + TAG_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cast_mdata_in = req_mdata[grant_reg];
   assign cast_edata_in = req_edata[grant_reg];

   mxint_tag_fifo #(
      .TAG_WIDTH (TAG_W),
      .DEPTH     (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_hs),
      .push_tag (grant_reg),
      .pop      (out_hs),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Return path: results are steered to the requester named by the oldest tag.
   always_comb begin
      rsp_valid      = '0;
      cast_out_ready = 1'b0;
      if (!fifo_empty) begin
         rsp_valid[fifo_head] = cast_out_valid;
         cast_out_ready       = rsp_ready[fifo_head];
      end
   end

   assign out_hs    = cast_out_valid & cast_out_ready;
   assign rsp_mdata = cast_mdata_out;
   assign rsp_edata = cast_edata_out;

`ifdef MXINT_CAST_ARB_STATS_EN
   logic [31:0] stat_cnt_reg [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stat_cnt_reg[gi] <= '0;
            else if (req_valid[gi] && req_ready[gi]) stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
         end
         assign stat_blocks[gi] = stat_cnt_reg[gi];
      end
   endgenerate
`endif

   // The cast engine must never present a result nobody is waiting for.
   a_out_valid_has_tag: assert property (@(posedge clk) disable iff (!rst)
      !(cast_out_valid && fifo_empty));
   a_no_ack_when_empty: assert property (@(posedge clk) disable iff (!rst)
      !(cast_out_ready && fifo_empty));

endmodule

// File: tb/tb_mxint_cast_arbiter.sv
// Randomized bench for mxint_cast_arbiter with a transaction-level arbitration model
// and a queue-based cast engine; checks handshakes, routing and data every cycle.
module tb_mxint_cast_arbiter;

   localparam int NR  = 3;
   localparam int BS  = 4;
   localparam int BL  = 4;
   localparam int MI  = 8;
   localparam int BW  = BS * 8 + 8;

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic [NR-1:0][BS-1:0][7:0] req_mdata;
   logic [NR-1:0][7:0]         req_edata;
   logic [NR-1:0]              req_valid;
   logic [NR-1:0]              req_ready;
   logic [BS-1:0][7:0]         cast_mdata_in;
   logic [7:0]                 cast_edata_in;
   logic                       cast_in_valid;
   logic                       cast_in_ready;
   logic [BS-1:0][7:0]         cast_mdata_out;
   logic [7:0]                 cast_edata_out;
   logic                       cast_out_valid;
   logic                       cast_out_ready;
   logic [BS-1:0][7:0]         rsp_mdata;
   logic [7:0]                 rsp_edata;
   logic [NR-1:0]              rsp_valid;
   logic [NR-1:0]              rsp_ready;
`ifdef MXINT_CAST_ARB_STATS_EN
   logic [NR-1:0][31:0]        stat_blocks;
`endif

   mxint_cast_arbiter #(
      .NUM_REQ(NR), .IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(8),
      .OUT_EXP_WIDTH(8), .BLOCK_SIZE(BS), .BURST_LEN(BL), .MAX_INFLIGHT(MI)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_mdata      (req_mdata),
      .req_edata      (req_edata),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .cast_mdata_in  (cast_mdata_in),
      .cast_edata_in  (cast_edata_in),
      .cast_in_valid  (cast_in_valid),
      .cast_in_ready  (cast_in_ready),
      .cast_mdata_out (cast_mdata_out),
      .cast_edata_out (cast_edata_out),
      .cast_out_valid (cast_out_valid),
      .cast_out_ready (cast_out_ready),
      .rsp_mdata      (rsp_mdata),
      .rsp_edata      (rsp_edata),
      .rsp_valid      (rsp_valid),
`ifdef MXINT_CAST_ARB_STATS_EN
      .stat_blocks    (stat_blocks),
`endif
      .rsp_ready      (rsp_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Model: who owns the engine, how many blocks this burst, where round-robin resumes,
   // and the requester ids / expected results in acceptance order.
   int            owner;
   int            taken;
   int            ptr;
   int            order_q[$];
   logic [BW-1:0] exp_blk_q[$];
   logic [BW-1:0] eng_q[$];
   logic          eng_valid;
   logic [BW-1:0] pend [NR];
   logic [NR-1:0] vld;
   logic [NR-1:0] acc_flag;
   logic [31:0]   acc_cnt [NR];
   logic          in_hs, out_hs;
   logic [BW-1:0] cap_blk;
   int            n_rsp;

   function automatic logic [BW-1:0] xform(input logic [BW-1:0] b);
      return {b[BW-1:BW-8] + 8'd3, b[BW-9:0] ^ 32'hA5A5_A5A5};
   endfunction

   function automatic logic [BW-1:0] rand_blk();
      return BW'({$urandom(), $urandom()});
   endfunction

   task automatic reset_model();
      owner = -1; taken = 0; ptr = 0;
      order_q.delete(); exp_blk_q.delete(); eng_q.delete();
      eng_valid = 1'b0; in_hs = 1'b0; out_hs = 1'b0;
      vld = '0; acc_flag = '0;
      for (int i = 0; i < NR; i++) acc_cnt[i] = '0;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NR; i++) begin
         req_mdata[i] = pend[i][BW-9:0];
         req_edata[i] = pend[i][BW-1:BW-8];
      end
      req_valid      = vld;
      cast_out_valid = eng_valid;
      if (eng_valid) {cast_edata_out, cast_mdata_out} = eng_q[0];
      else           {cast_edata_out, cast_mdata_out} = rand_blk();
   endtask

   // Phases: 0 single requester 1, 1 all valid, 2 engine output stalled,
   // 3 responders not ready, 4 random, 5 drain.
   task automatic drive(input int phase);
      logic just_acc;
      for (int i = 0; i < NR; i++) begin
         just_acc = acc_flag[i];
         if (just_acc) begin
            pend[i]     = rand_blk();
            acc_flag[i] = 1'b0;
         end
         case (phase)
            0:       vld[i] = (i == 1);
            1, 2, 3: vld[i] = 1'b1;
            4: begin
               if (vld[i] && !just_acc) vld[i] = ($urandom_range(99) >= 3);
               else                     vld[i] = ($urandom_range(99) < 60);
            end
            default: vld[i] = 1'b0;
         endcase
      end
      cast_in_ready = (phase == 4) ? ($urandom_range(99) < 80) : 1'b1;
      for (int i = 0; i < NR; i++) begin
         if (phase == 3)      rsp_ready[i] = 1'b0;
         else if (phase == 4) rsp_ready[i] = ($urandom_range(99) < 75);
         else                 rsp_ready[i] = 1'b1;
      end
      if (!eng_valid && eng_q.size() > 0 && phase != 2)
         eng_valid = (phase == 4) ? ($urandom_range(99) < 70) : 1'b1;
      apply_inputs();
   endtask

   // Compare DUT outputs against the model while inputs are stable.
   task automatic evaluate();
      logic [NR-1:0] exp_ready, exp_rv;
      logic          exp_civ, exp_cor, full;
      int            h;
      exp_ready = '0; exp_rv = '0; exp_civ = 1'b0; exp_cor = 1'b0;
      in_hs = 1'b0; out_hs = 1'b0;
      full = (order_q.size() >= MI);
      if (owner >= 0) begin
         exp_civ = req_valid[owner] && !full;
         exp_ready[owner] = cast_in_ready && !full;
         in_hs = exp_civ && cast_in_ready;
      end
      if (order_q.size() > 0) begin
         h = order_q[0];
         exp_rv[h] = cast_out_valid;
         exp_cor   = rsp_ready[h];
         out_hs    = cast_out_valid && rsp_ready[h];
      end
      check("req_ready",      64'(req_ready),      64'(exp_ready));
      check("cast_in_valid",  64'(cast_in_valid),  64'(exp_civ));
      check("rsp_valid",      64'(rsp_valid),      64'(exp_rv));
      check("cast_out_ready", 64'(cast_out_ready), 64'(exp_cor));
      if (in_hs) begin
         check("cast_in_data", 64'({cast_edata_in, cast_mdata_in}), 64'(pend[owner]));
         cap_blk = xform({cast_edata_in, cast_mdata_in});
      end
      if (out_hs) begin
         check("rsp_data", 64'({rsp_edata, rsp_mdata}), 64'(exp_blk_q[0]));
         n_rsp++;
         $display("rsp %0d req=%0d data=%h", n_rsp, order_q[0], {rsp_edata, rsp_mdata});
      end
`ifdef MXINT_CAST_ARB_STATS_EN
      for (int i = 0; i < NR; i++) check("stat_blocks", 64'(stat_blocks[i]), 64'(acc_cnt[i]));
`endif
   endtask

   // Apply the handshakes that happened at this clock edge to the model.
   task automatic advance();
      if (out_hs) begin
         void'(order_q.pop_front());
         void'(exp_blk_q.pop_front());
         void'(eng_q.pop_front());
         eng_valid = 1'b0;
      end
      if (in_hs) begin
         order_q.push_back(owner);
         exp_blk_q.push_back(xform(pend[owner]));
         eng_q.push_back(cap_blk);
         acc_cnt[owner] = acc_cnt[owner] + 32'd1;
         acc_flag[owner] = 1'b1;
         taken++;
      end
      if (owner >= 0) begin
         if (!req_valid[owner] || taken == BL) begin
            ptr   = (owner + 1) % NR;
            owner = -1;
         end
      end else if (req_valid != '0) begin
         for (int k = NR - 1; k >= 0; k--)
            if (req_valid[(ptr + k) % NR]) owner = (ptr + k) % NR;
         taken = 0;
      end
   endtask

   task automatic do_cycle(input int phase);
      @(posedge clk);
      advance();
      #1;
      drive(phase);
      @(negedge clk);
      evaluate();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"},      64'(req_ready),      64'(0));
      check({tag, "_cast_in_valid"},  64'(cast_in_valid),  64'(0));
      check({tag, "_rsp_valid"},      64'(rsp_valid),      64'(0));
      check({tag, "_cast_out_ready"}, 64'(cast_out_ready), 64'(0));
`ifdef MXINT_CAST_ARB_STATS_EN
      for (int i = 0; i < NR; i++) check({tag, "_stat"}, 64'(stat_blocks[i]), 64'(0));
`endif
   endtask

   initial begin
      n_rsp = 0;
      for (int i = 0; i < NR; i++) pend[i] = rand_blk();
      reset_model();
      cast_in_ready = 1'b1;
      rsp_ready     = '1;
      vld           = '1;
      apply_inputs();
      #12;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      vld = '0;
      apply_inputs();
      @(negedge clk);
      evaluate();

      repeat (30)  do_cycle(0);
      repeat (40)  do_cycle(1);
      repeat (25)  do_cycle(2);
      repeat (6)   do_cycle(3);
      repeat (600) do_cycle(4);

      // Fill tags with the engine output stalled, then reset mid-burst.
      repeat (6) do_cycle(2);
      @(posedge clk);
      advance();
      #1;
      rst = 1'b0;
      #1;
      check_idle_outputs("midreset");
      reset_model();
      apply_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      evaluate();

      repeat (300) do_cycle(4);
      for (int c = 0; c < 300 && (order_q.size() > 0 || owner >= 0); c++) do_cycle(5);
      check("drain_pending", 64'(order_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
